// File: rtl/bp_pkg.sv
// bp_pkg: shared types and constants for the gselect predictor update path
package bp_pkg;
  localparam int GHR_MAX = 16;
  localparam logic [1:0] PHT_INIT = 2'b01;
  typedef struct packed {
    logic [31:0] pc;
    logic isbranch;
    logic taken;
    logic [31:0] target;
    logic [GHR_MAX-1:0] ghr;
  } bp_train_t;
  typedef enum logic [1:0] {SWEEP, RUN, FWAIT} bp_state_e;
endpackage

// File: rtl/bp_train_fifo.sv
// bp_train_fifo: two-write one-read in-order training queue with occupancy count
module bp_train_fifo
  import bp_pkg::*;
#(
  parameter int QDEPTH = 4,
  parameter type T = bp_train_t,
  localparam int AW = $clog2(QDEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push0,
  input  logic          push1,
  input  T              d0,
  input  T              d1,
  input  logic          pop,
  output T              head,
  output logic [CW-1:0] count
);
  T mem [QDEPTH];
  logic [AW-1:0] wp, rp;
  assign head = mem[rp];
  // storage: port 1 lands behind port 0 when both write
  always_ff @(posedge clk) begin
    if (push0) mem[wp] <= d0;
    if (push1) mem[push0 ? wp + AW'(1) : wp] <= d1;
  end
  // pointers wrap naturally at the power-of-two depth; clear wins over traffic
  always_ff @(posedge clk)
    if (rst || clr) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(push0) + AW'(push1);
      rp <= rp + AW'(pop);
      count <= count + CW'(push0) + CW'(push1) - CW'(pop);
    end
endmodule

// File: rtl/bp_update_sched.sv
// bp_update_sched: queues retire training records, commits one per cycle, sweeps tables clear
module bp_update_sched
  import bp_pkg::*;
#(
  parameter int GHR_W = 8,
  parameter int PC_BITS = 8,
  parameter int BTB_IDX_W = 10,
  parameter int QDEPTH = 4,
  localparam int PHT_IDX_W = GHR_W + PC_BITS,
  localparam int SW = PHT_IDX_W > BTB_IDX_W ? PHT_IDX_W : BTB_IDX_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tr0_valid,
  output logic                 tr0_ready,
  input  logic [31:0]          tr0_pc,
  input  logic                 tr0_isbranch,
  input  logic                 tr0_taken,
  input  logic [31:0]          tr0_target,
  input  logic [GHR_W-1:0]     tr0_ghr,
  input  logic                 tr1_valid,
  output logic                 tr1_ready,
  input  logic [31:0]          tr1_pc,
  input  logic                 tr1_isbranch,
  input  logic                 tr1_taken,
  input  logic [31:0]          tr1_target,
  input  logic [GHR_W-1:0]     tr1_ghr,
  input  logic                 flush,
  output logic                 busy,
  output logic                 clr_pht_en,
  output logic                 clr_btb_en,
  output logic [SW-1:0]        clr_idx,
  output logic                 cmt_valid,
  input  logic                 cmt_ready,
  output logic [31:0]          cmt_pc,
  output logic                 cmt_isbranch,
  output logic                 cmt_taken,
  output logic [31:0]          cmt_target,
  output logic [GHR_W-1:0]     cmt_ghr,
  output logic [PHT_IDX_W-1:0] cmt_pht_idx,
  output logic [BTB_IDX_W-1:0] cmt_btb_idx
);
  localparam int CW = $clog2(QDEPTH) + 1;
  bp_state_e state, state_n;
  logic [SW-1:0] clr_idx_n;
  logic [CW-1:0] count;
  bp_train_t d0, d1, head;
  logic push0, push1, pop, qclr, unused_ghr;
  assign d0 = '{pc: tr0_pc, isbranch: tr0_isbranch, taken: tr0_taken, target: tr0_target, ghr: GHR_MAX'(tr0_ghr)};
  assign d1 = '{pc: tr1_pc, isbranch: tr1_isbranch, taken: tr1_taken, target: tr1_target, ghr: GHR_MAX'(tr1_ghr)};
  assign push0 = tr0_valid && tr0_ready;
  assign push1 = tr1_valid && tr1_ready;
  assign pop = cmt_valid && cmt_ready;
  assign cmt_pc = head.pc;
  assign cmt_isbranch = head.isbranch;
  assign cmt_taken = head.taken;
  assign cmt_target = head.target;
  assign cmt_ghr = head.ghr[GHR_W-1:0];
  assign cmt_pht_idx = {cmt_ghr, head.pc[PC_BITS+1:2]};
  assign cmt_btb_idx = head.pc[BTB_IDX_W+1:2];
  assign unused_ghr = ^head.ghr;
  bp_train_fifo #(.QDEPTH(QDEPTH), .T(bp_train_t)) u_fifo (
    .clk(clk), .rst(rst), .clr(qclr),
    .push0(push0), .push1(push1), .d0(d0), .d1(d1),
    .pop(pop), .head(head), .count(count)
  );
  // outputs from registered state; flush stalls in FWAIT only while the head is unaccepted
  always_comb begin
    state_n = state;
    clr_idx_n = clr_idx;
    qclr = 1'b0;
    busy = state == SWEEP;
    clr_pht_en = busy && (clr_idx >> PHT_IDX_W) == '0;
    clr_btb_en = busy && (clr_idx >> BTB_IDX_W) == '0;
    tr0_ready = state == RUN && count < CW'(QDEPTH);
    tr1_ready = state == RUN && count < CW'(QDEPTH - 1);
    cmt_valid = state != SWEEP && count != '0;
    case (state)
      SWEEP: begin
        clr_idx_n = flush ? '0 : clr_idx + SW'(1);
        state_n = !flush && &clr_idx ? RUN : SWEEP;
      end
      RUN: if (flush) begin
        state_n = cmt_valid && !cmt_ready ? FWAIT : SWEEP;
        qclr = !(cmt_valid && !cmt_ready);
      end
      FWAIT: if (cmt_ready) begin
        state_n = SWEEP;
        qclr = 1'b1;
      end
      default: state_n = SWEEP;
    endcase
  end
  // state and sweep index; the index wraps to 0 when the sweep ends
  always_ff @(posedge clk)
    if (rst) begin
      state <= SWEEP;
      clr_idx <= '0;
    end else begin
      state <= state_n;
      clr_idx <= clr_idx_n;
    end
endmodule

// File: tb/tb_bp_update_sched.sv
// tb_bp_update_sched: directed bench with queue model for bp_update_sched
module tb_bp_update_sched;
  localparam int QD = 4;
  logic clk = 0, rst = 1;
  logic tr0_valid = 0, tr0_isbranch = 0, tr0_taken = 0, tr1_valid = 0, tr1_isbranch = 0, tr1_taken = 0;
  logic [31:0] tr0_pc = 0, tr0_target = 0, tr1_pc = 0, tr1_target = 0;
  logic [1:0] tr0_ghr = 0, tr1_ghr = 0;
  logic flush = 0, cmt_ready = 0;
  logic tr0_ready, tr1_ready, busy, clr_pht_en, clr_btb_en, cmt_valid, cmt_isbranch, cmt_taken;
  logic [3:0] clr_idx, cmt_pht_idx;
  logic [2:0] cmt_btb_idx;
  logic [31:0] cmt_pc, cmt_target;
  logic [1:0] cmt_ghr;
  int n_chk = 0, n_fail = 0, seen_bad = 0;

  bp_update_sched #(.GHR_W(2), .PC_BITS(2), .BTB_IDX_W(3), .QDEPTH(QD)) dut (
    .clk(clk), .rst(rst),
    .tr0_valid(tr0_valid), .tr0_ready(tr0_ready), .tr0_pc(tr0_pc), .tr0_isbranch(tr0_isbranch),
    .tr0_taken(tr0_taken), .tr0_target(tr0_target), .tr0_ghr(tr0_ghr),
    .tr1_valid(tr1_valid), .tr1_ready(tr1_ready), .tr1_pc(tr1_pc), .tr1_isbranch(tr1_isbranch),
    .tr1_taken(tr1_taken), .tr1_target(tr1_target), .tr1_ghr(tr1_ghr),
    .flush(flush), .busy(busy), .clr_pht_en(clr_pht_en), .clr_btb_en(clr_btb_en), .clr_idx(clr_idx),
    .cmt_valid(cmt_valid), .cmt_ready(cmt_ready), .cmt_pc(cmt_pc), .cmt_isbranch(cmt_isbranch),
    .cmt_taken(cmt_taken), .cmt_target(cmt_target), .cmt_ghr(cmt_ghr),
    .cmt_pht_idx(cmt_pht_idx), .cmt_btb_idx(cmt_btb_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {logic [31:0] pc; logic ib; logic tk; logic [31:0] tg; logic [1:0] gh;} rec_t;
  rec_t q[$];
  rec_t r;
  int sw = 0;
  bit hold = 0, started = 0, cv, p0, p1;

  function automatic bit e_r0(); return sw < 0 && !hold && q.size() <= QD - 1; endfunction
  function automatic bit e_r1(); return sw < 0 && !hold && q.size() <= QD - 2; endfunction
  function automatic bit e_cv(); return sw < 0 && q.size() > 0; endfunction

  // compare the current cycle against the model, then advance the model with this cycle's inputs
  always @(negedge clk) begin
    if (started) begin
      chk("busy", busy, sw >= 0);
      chk("clr_idx", clr_idx, sw >= 0 ? sw : 0);
      chk("clr_pht_en", clr_pht_en, sw >= 0 && sw < 16);
      chk("clr_btb_en", clr_btb_en, sw >= 0 && sw < 8);
      chk("tr0_ready", tr0_ready, e_r0());
      chk("tr1_ready", tr1_ready, e_r1());
      chk("cmt_valid", cmt_valid, e_cv());
      if (e_cv()) begin
        chk("cmt_pc", cmt_pc, q[0].pc);
        chk("cmt_isbranch", cmt_isbranch, q[0].ib);
        chk("cmt_taken", cmt_taken, q[0].tk);
        chk("cmt_target", cmt_target, q[0].tg);
        chk("cmt_ghr", cmt_ghr, q[0].gh);
        chk("cmt_pht_idx", cmt_pht_idx, {q[0].gh, q[0].pc[3:2]});
        chk("cmt_btb_idx", cmt_btb_idx, q[0].pc[4:2]);
      end
      if (cmt_valid && cmt_ready && cmt_pc inside {32'h50, 32'h200, 32'h60, 32'h64, 32'h68}) seen_bad++;
    end
    cv = e_cv();
    p0 = tr0_valid && e_r0();
    p1 = tr1_valid && e_r1();
    if (rst) begin
      q.delete();
      sw = 0;
      hold = 0;
      started = 1;
    end else if (sw >= 0) sw = flush ? 0 : (sw == 15 ? -1 : sw + 1);
    else if (hold) begin
      if (cmt_ready) begin
        q.delete();
        sw = 0;
        hold = 0;
      end
    end else if (flush && cv && !cmt_ready) hold = 1;
    else if (flush) begin
      q.delete();
      sw = 0;
    end else begin
      if (cv && cmt_ready) void'(q.pop_front());
      if (p0) begin
        r.pc = tr0_pc; r.ib = tr0_isbranch; r.tk = tr0_taken; r.tg = tr0_target; r.gh = tr0_ghr;
        q.push_back(r);
      end
      if (p1) begin
        r.pc = tr1_pc; r.ib = tr1_isbranch; r.tk = tr1_taken; r.tg = tr1_target; r.gh = tr1_ghr;
        q.push_back(r);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic v, input logic [31:0] pc, input logic [1:0] g);
    tr0_valid = v; tr0_pc = pc; tr0_isbranch = ~pc[3]; tr0_taken = pc[2]; tr0_target = pc + 32'h1000; tr0_ghr = g;
  endtask

  task automatic drv1(input logic v, input logic [31:0] pc, input logic [1:0] g);
    tr1_valid = v; tr1_pc = pc; tr1_isbranch = ~pc[3]; tr1_taken = pc[2]; tr1_target = pc + 32'h1000; tr1_ghr = g;
  endtask

  task automatic sweep_len(input string nm);
    int n = 0;
    while (busy && n < 40) begin
      n++;
      step();
    end
    chk(nm, n, 16);
  endtask

  initial begin
    int n;
    step();
    step();
    rst = 0;
    chk("rst_busy", busy, 1);
    chk("rst_clr_idx", clr_idx, 0);
    chk("rst_pht_en", clr_pht_en, 1);
    chk("rst_btb_en", clr_btb_en, 1);
    chk("rst_cmt_valid", cmt_valid, 0);
    chk("rst_tr0_ready", tr0_ready, 0);
    chk("rst_tr1_ready", tr1_ready, 0);
    n = 0;
    while (busy && n < 40) begin
      chk("sweep_idx", clr_idx, n);
      chk("sweep_btb_en", clr_btb_en, n < 8);
      n++;
      step();
    end
    chk("sweep_cycles", n, 16);
    chk("run_tr0_ready", tr0_ready, 1);
    chk("run_tr1_ready", tr1_ready, 1);

    drv0(1, 32'h10, 2'b11);
    drv1(1, 32'h20, 2'b00);
    cmt_ready = 1;
    step();
    drv0(0, 0, 0);
    drv1(0, 0, 0);
    chk("dual_v0", cmt_valid, 1);
    chk("dual_pc0", cmt_pc, 32'h10);
    chk("dual_pht", cmt_pht_idx, 4'b1100);
    chk("dual_btb", cmt_btb_idx, 3'b100);
    step();
    chk("dual_v1", cmt_valid, 1);
    chk("dual_pc1", cmt_pc, 32'h20);
    step();
    chk("dual_empty", cmt_valid, 0);

    cmt_ready = 0;
    for (int i = 0; i < 4; i++) begin
      drv0(1, 32'h100 + 32'(4 * i), 2'(i));
      step();
      if (i == 2) begin
        chk("bp_c3_tr1", tr1_ready, 0);
        chk("bp_c3_tr0", tr0_ready, 1);
      end
      if (i == 3) chk("bp_c4_tr0", tr0_ready, 0);
    end
    drv0(1, 32'h200, 0);
    cmt_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_order_v", cmt_valid, 1);
      chk("bp_order_pc", cmt_pc, 32'h100 + 32'(4 * i));
      step();
      if (i == 0) tr0_valid = 0;
    end
    chk("bp_drained", cmt_valid, 0);

    cmt_ready = 0;
    drv0(1, 32'h40, 2'b10);
    step();
    drv0(0, 0, 0);
    flush = 1;
    step();
    chk("fw_valid", cmt_valid, 1);
    chk("fw_pc", cmt_pc, 32'h40);
    chk("fw_tr0_ready", tr0_ready, 0);
    chk("fw_busy", busy, 0);
    step();
    flush = 0;
    cmt_ready = 1;
    chk("fw_hold_pc", cmt_pc, 32'h40);
    step();
    cmt_ready = 0;
    chk("fw_busy_after", busy, 1);
    chk("fw_idx_after", clr_idx, 0);
    chk("fw_valid_after", cmt_valid, 0);
    sweep_len("fw_sweep_len");

    drv0(1, 32'h50, 2'b01);
    flush = 1;
    cmt_ready = 1;
    step();
    drv0(0, 0, 0);
    flush = 0;
    chk("fr_busy", busy, 1);
    chk("fr_idx", clr_idx, 0);
    n = 0;
    while (clr_idx != 4'd9 && n < 40) begin
      n++;
      step();
    end
    chk("ms_reach9", clr_idx, 9);
    flush = 1;
    step();
    flush = 0;
    chk("ms_restart", clr_idx, 0);
    sweep_len("ms_sweep_len");

    cmt_ready = 0;
    for (int i = 0; i < 3; i++) begin
      drv0(1, 32'h60 + 32'(4 * i), 0);
      step();
    end
    drv0(0, 0, 0);
    chk("rm_queued", cmt_valid, 1);
    rst = 1;
    step();
    rst = 0;
    chk("rm_valid", cmt_valid, 0);
    chk("rm_busy", busy, 1);
    chk("rm_idx", clr_idx, 0);
    cmt_ready = 1;
    sweep_len("rm_sweep_len");
    repeat (3) step();
    chk("rm_no_commit", cmt_valid, 0);
    chk("discarded_never_committed", seen_bad, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
